// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash controller slice.
// - SPI controller state codes, as driven on the assembler's `state` input.
// - Assembler FSM state type.
package spi_flash_pkg;

  localparam logic [3:0] ST_IDLE           = 4'h0;
  localparam logic [3:0] ST_SEND_CODE_ADDR = 4'h1;
  localparam logic [3:0] ST_READ_WAIT      = 4'h2;
  localparam logic [3:0] ST_WRITE_DATA     = 4'h3;
  localparam logic [3:0] ST_FINISH_DONE    = 4'h4;

  typedef enum logic {
    AS_IDLE    = 1'b0,
    AS_COLLECT = 1'b1
  } asm_state_e;

endpackage

// File: rtl/spi_flash_word_fifo.sv
// Synchronous show-ahead FIFO for assembled words.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data
//                (taken when not full, or when a pop happens in the same cycle)
//   pop        : remove the head (ignored when empty)
//   dout       : head entry, forced to 0 while empty
//   full, empty, level : occupancy status
module spi_flash_word_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             wr_en, rd_en;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  // A pop frees the slot in the same cycle, so a push to a full FIFO still lands.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  assign dout = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/spi_flash_word_assembler.sv
// Packs the SPI read byte stream into BYTES_PER_WORD-byte words, selectable byte order,
// with zero-padded partial final words. Words are buffered in a FIFO and offered on a
// valid/ready port.
// Ports:
//   spi_clk, spi_resetn   : clock, asynchronous active-low reset
//   state                 : SPI controller state code; bytes are collected in ST_READ_WAIT
//   cmd_done              : ends the burst
//   cmd_rvalid/cmd_rdata  : read byte strobe and data
//   big_endian            : byte order, latched at burst start
//   out_valid/out_ready   : head handshake
//   out_data/out_bytes/out_last : head word, valid byte count, last-of-burst
//   fifo_level            : words held
//   overflow/clr_overflow : sticky drop flag and its clear
module spi_flash_word_assembler
  import spi_flash_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned DEPTH          = 4,
  parameter logic [3:0]  ST_READ_WAIT   = spi_flash_pkg::ST_READ_WAIT
) (
  input  logic                                spi_clk,
  input  logic                                spi_resetn,
  input  logic [3:0]                          state,
  input  logic                                cmd_done,
  input  logic                                cmd_rvalid,
  input  logic [7:0]                          cmd_rdata,
  input  logic                                big_endian,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [8*BYTES_PER_WORD-1:0]         out_data,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0] out_bytes,
  output logic                                out_last,
  output logic [$clog2(DEPTH+1)-1:0]          fifo_level,
  output logic                                overflow,
  input  logic                                clr_overflow
);

  localparam int unsigned W  = 8 * BYTES_PER_WORD;
  localparam int unsigned KW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned BW = $clog2(BYTES_PER_WORD + 1);
  localparam int unsigned RW = W + BW + 1;
  localparam logic [KW-1:0] K_LAST = KW'(BYTES_PER_WORD - 1);

  asm_state_e    fsm_q, fsm_d;
  logic          be_q, be_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  asm_q, asm_d;
  logic          ovf_q, ovf_d;

  logic          in_rw, acc, be_eff;
  int unsigned   lane;
  logic [W-1:0]  word_w;
  logic [BW-1:0] k_after;

  logic          push, push_last;
  logic [BW-1:0] push_bytes;
  logic          pop, fifo_full, fifo_empty;
  logic [RW-1:0] fifo_dout;

  assign in_rw   = (state == ST_READ_WAIT);
  assign acc     = in_rw & cmd_rvalid;
  // The byte arriving on the IDLE->COLLECT cycle must use the mode being latched.
  assign be_eff  = (fsm_q == AS_IDLE) ? big_endian : be_q;
  assign k_after = BW'(k_q) + BW'(acc);

  always_comb begin
    lane   = be_eff ? (BYTES_PER_WORD - 1 - 32'(k_q)) : 32'(k_q);
    word_w = asm_q;
    if (acc) word_w[8*lane +: 8] = cmd_rdata;
  end

  always_comb begin
    logic active;
    fsm_d      = fsm_q;
    be_d       = be_q;
    k_d        = k_q;
    asm_d      = asm_q;
    push       = 1'b0;
    push_bytes = BW'(BYTES_PER_WORD);
    push_last  = 1'b0;
    active     = 1'b0;

    case (fsm_q)
      AS_IDLE: begin
        if (in_rw) begin
          fsm_d  = AS_COLLECT;
          be_d   = big_endian;
          active = 1'b1;
        end
      end
      AS_COLLECT: active = 1'b1;
      default:    fsm_d  = AS_IDLE;
    endcase

    if (active) begin
      if (acc && (k_q == K_LAST)) begin
        push       = 1'b1;
        push_bytes = BW'(BYTES_PER_WORD);
        push_last  = cmd_done;
        k_d        = '0;
        asm_d      = '0;
        if (cmd_done) fsm_d = AS_IDLE;
      end else if (cmd_done) begin
        if (k_after != '0) begin
          push       = 1'b1;
          push_bytes = k_after;
          push_last  = 1'b1;
        end
        k_d   = '0;
        asm_d = '0;
        fsm_d = AS_IDLE;
      end else if (!in_rw) begin
        // Controller abandoned the read: drop the partial word silently.
        k_d   = '0;
        asm_d = '0;
        fsm_d = AS_IDLE;
      end else if (acc) begin
        k_d   = k_q + KW'(1);
        asm_d = word_w;
      end
    end
  end

  assign pop = ~fifo_empty & out_ready;

  always_comb begin
    ovf_d = ovf_q;
    if (clr_overflow) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      fsm_q <= AS_IDLE;
      be_q  <= 1'b0;
      k_q   <= '0;
      asm_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      be_q  <= be_d;
      k_q   <= k_d;
      asm_q <= asm_d;
      ovf_q <= ovf_d;
    end
  end

  spi_flash_word_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (spi_clk),
    .rst_n (spi_resetn),
    .push  (push),
    .pop   (pop),
    .din   ({push_last, push_bytes, word_w}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_valid                       = ~fifo_empty;
  assign {out_last, out_bytes, out_data} = fifo_dout;
  assign overflow                        = ovf_q;

endmodule
